// File: rtl/dmem_seq_pkg.sv
// Shared encodings and helpers for the byte-serial data-memory access sequencer.
// The sequencer state is kept as plain localparam constants so older tools can consume it.
package dmem_seq_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Number of byte beats for an access size; the reserved encoding yields none.
    function automatic logic [2:0] beats_for_size(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Right-aligned load result extension (byte/half/word, signed or unsigned).
// Purely combinational so the writeback mux can reuse it.
module dmem_load_extend
    import dmem_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] asm_i,
    input  logic [1:0]            size_i,
    input  logic                  is_unsigned_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    localparam int HALF_WIDTH = 2 * DATA_WIDTH;

    logic byte_sign_s;
    logic half_sign_s;

    assign byte_sign_s = ~is_unsigned_i & asm_i[DATA_WIDTH-1];
    assign half_sign_s = ~is_unsigned_i & asm_i[HALF_WIDTH-1];

    // Replicate the sign (or zero) above the loaded field.
    always_comb begin
        case (size_i)
            SZ_BYTE: rdata_o = {{(WORD_WIDTH-DATA_WIDTH){byte_sign_s}}, asm_i[DATA_WIDTH-1:0]};
            SZ_HALF: rdata_o = {{(WORD_WIDTH-HALF_WIDTH){half_sign_s}}, asm_i[HALF_WIDTH-1:0]};
            default: rdata_o = asm_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_sequencer.sv
// Serialises 8/16/32-bit loads and stores onto a byte-wide memory, MSB first.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses with err.
module dmem_access_sequencer
    import dmem_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int MEMORY_SIZE    = 16384,
    parameter int ADDRESS_LENGTH = $clog2(MEMORY_SIZE),
    parameter int WORD_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [1:0]                size,
    input  logic                      is_unsigned,
    input  logic [ADDRESS_LENGTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0]     wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [WORD_WIDTH-1:0]     rdata,
    output logic [ADDRESS_LENGTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      mem_we,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int ASM_W = WORD_WIDTH - DATA_WIDTH;

    state_t                    state_q, state_d;
    logic                      we_q, we_d;
    logic [1:0]                size_q, size_d;
    logic                      uns_q, uns_d;
    logic [1:0]                beat_q, beat_d;
    logic [WORD_WIDTH-1:0]     sdata_q, sdata_d;
    logic [ASM_W-1:0]          asm_q, asm_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [WORD_WIDTH-1:0]     rdata_q, rdata_d;
    logic [ADDRESS_LENGTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic                      mem_we_q, mem_we_d;

    logic                      reject_s;
    logic                      last_beat_s;
    logic [WORD_WIDTH-1:0]     aligned_s;
    logic [WORD_WIDTH-1:0]     asm_next_s;
    logic [WORD_WIDTH-1:0]     ext_s;

`ifdef DMEM_ALIGN_CHECK_EN
    assign reject_s = (size == SZ_RSVD)
                   || ((size == SZ_HALF) && (addr[0] != 1'b0))
                   || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    assign reject_s = (size == SZ_RSVD);
`endif

    assign last_beat_s = ({1'b0, beat_q} == (beats_for_size(size_q) - 3'd1));
    assign asm_next_s  = {asm_q, mem_rdata};

    // Left-justify store data so every beat simply takes the top byte.
    always_comb begin
        case (size)
            SZ_BYTE: aligned_s = {wdata[DATA_WIDTH-1:0], {ASM_W{1'b0}}};
            SZ_HALF: aligned_s = {wdata[2*DATA_WIDTH-1:0], {(WORD_WIDTH-2*DATA_WIDTH){1'b0}}};
            default: aligned_s = wdata;
        endcase
    end

    dmem_load_extend #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_extend (
        .asm_i         (asm_next_s),
        .size_i        (size_q),
        .is_unsigned_i (uns_q),
        .rdata_o       (ext_s)
    );

    // Next-state logic; DONE accepts a new request exactly like IDLE.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        beat_d      = beat_q;
        sdata_d     = sdata_q;
        asm_d       = asm_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    we_d   = we;
                    size_d = size;
                    uns_d  = is_unsigned;
                    busy_d = 1'b1;
                    if (reject_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_ACCESS;
                        beat_d     = 2'd0;
                        asm_d      = {ASM_W{1'b0}};
                        mem_addr_d = addr;
                        mem_we_d   = we;
                        if (we) begin
                            mem_wdata_d = aligned_s[WORD_WIDTH-1 -: DATA_WIDTH];
                            sdata_d     = aligned_s << DATA_WIDTH;
                        end else begin
                            sdata_d = sdata_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    asm_d = asm_next_s[ASM_W-1:0];
                end else begin
                    asm_d = asm_q;
                end
                if (last_beat_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = ext_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    beat_d     = beat_q + 2'd1;
                    mem_addr_d = mem_addr_q + ADDRESS_LENGTH'(1);
                    mem_we_d   = we_q;
                    if (we_q) begin
                        mem_wdata_d = sdata_q[WORD_WIDTH-1 -: DATA_WIDTH];
                        sdata_d     = sdata_q << DATA_WIDTH;
                    end else begin
                        sdata_d = sdata_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset abandons any partial access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            beat_q      <= 2'd0;
            sdata_q     <= {WORD_WIDTH{1'b0}};
            asm_q       <= {ASM_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= {WORD_WIDTH{1'b0}};
            mem_addr_q  <= {ADDRESS_LENGTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            beat_q      <= beat_d;
            sdata_q     <= sdata_d;
            asm_q       <= asm_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule
